sound_mixer_gain: RTL and testbench

- Parametrised successor to the fixed attenuator-plus-mixer chain used for the cartridge sound outputs.
- Sums COUNT signed sound channels, each with a runtime-programmable gain and a mute bit, then saturates the result to the output width.
- Time-multiplexed: one shared multiplier, one channel per cycle, started by a sample strobe. Produces one mixed sample per strobe.
- Sits between the cartridge sound sources and the external/internal sound output ports.

---
 rtl/sound_mixer_gain.sv | 208 ++++++++++++++++++++
 tb/tb_sound_mixer_gain.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer_gain.sv
// ---------------------------------------------------------------------------
// sound_mixer_gain
//
// Time-multiplexed gain-and-mix stage for the cartridge sound sources.
// Each SAMPLE_STB snapshots COUNT signed channels, their mute bits and their
// gains, then walks the channels through one shared multiplier (one channel
// per cycle), accumulates at full precision, rescales by the unity gain and
// saturates to WIDTH bits. One mixed sample is produced per accepted strobe.
//
// Ports:
//   CLK         system clock
//   RESET       asynchronous, active-high reset
//   IN_SIGNAL   COUNT signed samples, channel k at [k*WIDTH +: WIDTH]
//   MUTE        per-channel mute (1 = channel contributes 0)
//   SAMPLE_STB  one-cycle pulse that starts a mix
//   GAIN_WE     gain register write enable
//   GAIN_SEL    channel index for the gain write (>= COUNT is ignored)
//   GAIN_DATA   unsigned gain value; unity = 2^(GAIN_WIDTH-1)
//   OUT_SIGNAL  signed mixed sample, held until the next OUT_VALID
//   OUT_VALID   one-cycle pulse when OUT_SIGNAL updates
//   CLIP        saturation flag belonging to the current OUT_SIGNAL
//   BUSY        high while a mix is in progress
//   DROP        one-cycle pulse after a strobe that arrived while BUSY
// ---------------------------------------------------------------------------
module sound_mixer_gain #(
    parameter int COUNT      = 4,
    parameter int WIDTH      = 16,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [COUNT*WIDTH-1:0]  IN_SIGNAL,
    input  logic [COUNT-1:0]        MUTE,
    input  logic                    SAMPLE_STB,
    input  logic                    GAIN_WE,
    input  logic [3:0]              GAIN_SEL,
    input  logic [GAIN_WIDTH-1:0]   GAIN_DATA,
    output logic [WIDTH-1:0]        OUT_SIGNAL,
    output logic                    OUT_VALID,
    output logic                    CLIP,
    output logic                    BUSY,
    output logic                    DROP
);

    // Product of a signed sample and a zero-extended gain.
    localparam int PROD_W = WIDTH + GAIN_WIDTH + 1;
    // Sum of COUNT products cannot overflow this width.
    localparam int ACC_W  = PROD_W + $clog2(COUNT);
    localparam int IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] OUT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SAT
    } state_t;

    // Control and result state
    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]          out_signal_q, out_signal_d;
    logic                      clip_q, clip_d;
    logic                      valid_q, valid_d;
    logic                      drop_q, drop_d;

    // Live gain file
    logic [GAIN_WIDTH-1:0]     gain_q [COUNT];
    logic [GAIN_WIDTH-1:0]     gain_d [COUNT];

    // Per-mix snapshot of inputs, mutes and gains
    logic signed [WIDTH-1:0]   smp_q [COUNT];
    logic signed [WIDTH-1:0]   smp_d [COUNT];
    logic [GAIN_WIDTH-1:0]     snap_gain_q [COUNT];
    logic [GAIN_WIDTH-1:0]     snap_gain_d [COUNT];
    logic [COUNT-1:0]          mute_q, mute_d;

    // Shared multiplier datapath
    logic signed [PROD_W-1:0]  smp_ext;
    logic signed [PROD_W-1:0]  gain_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   scaled;

    always_comb begin
        // Sample is sign-extended, gain zero-extended, so the multiply is a
        // plain signed product of two PROD_W operands.
        smp_ext  = PROD_W'(smp_q[idx_q]);
        gain_ext = PROD_W'(snap_gain_q[idx_q]);
        prod     = mute_q[idx_q] ? '0 : smp_ext * gain_ext;
        // Arithmetic shift floors toward -infinity, removing the unity scale.
        scaled   = acc_q >>> (GAIN_WIDTH - 1);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        out_signal_d = out_signal_q;
        clip_d       = clip_q;
        valid_d      = 1'b0;
        drop_d       = SAMPLE_STB && (state_q != ST_IDLE);
        gain_d       = gain_q;
        smp_d        = smp_q;
        snap_gain_d  = snap_gain_q;
        mute_d       = mute_q;

        // Gain writes are accepted in any state; an out-of-range index
        // simply matches no channel.
        for (int k = 0; k < COUNT; k++) begin
            if (GAIN_WE && (GAIN_SEL == 4'(k))) begin
                gain_d[k] = GAIN_DATA;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (SAMPLE_STB) begin
                    // Snapshot takes gain_q, so a write in this same cycle
                    // only applies from the next mix.
                    for (int k = 0; k < COUNT; k++) begin
                        smp_d[k]       = IN_SIGNAL[k*WIDTH +: WIDTH];
                        snap_gain_d[k] = gain_q[k];
                    end
                    mute_d  = MUTE;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_SAT: begin
                if (scaled > ACC_W'(OUT_MAX)) begin
                    out_signal_d = OUT_MAX;
                    clip_d       = 1'b1;
                end else if (scaled < ACC_W'(OUT_MIN)) begin
                    out_signal_d = OUT_MIN;
                    clip_d       = 1'b1;
                end else begin
                    out_signal_d = scaled[WIDTH-1:0];
                    clip_d       = 1'b0;
                end
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            out_signal_q <= '0;
            clip_q       <= 1'b0;
            valid_q      <= 1'b0;
            drop_q       <= 1'b0;
            for (int k = 0; k < COUNT; k++) begin
                gain_q[k] <= GAIN_UNITY;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            out_signal_q <= out_signal_d;
            clip_q       <= clip_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
            gain_q       <= gain_d;
        end
    end

    // NOTE: the snapshot storage is deliberately left without reset; it is
    // always loaded by the strobe before ACCUM reads it, and skipping the
    // reset keeps it plain storage.
    always_ff @(posedge CLK) begin
        smp_q       <= smp_d;
        snap_gain_q <= snap_gain_d;
        mute_q      <= mute_d;
    end

    assign OUT_SIGNAL = out_signal_q;
    assign OUT_VALID  = valid_q;
    assign CLIP       = clip_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign DROP       = drop_q;

endmodule

// File: tb/tb_sound_mixer_gain.sv
// ---------------------------------------------------------------------------
// tb_sound_mixer_gain
//
// Self-checking bench for sound_mixer_gain (COUNT=4, WIDTH=16, GAIN_WIDTH=8).
// A transaction-level model predicts, for each accepted strobe, the mixed
// and saturated value and the cycle it appears; a per-cycle compare process
// checks every output against it. Directed scenarios pin literal results,
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_sound_mixer_gain;

    localparam int COUNT      = 4;
    localparam int WIDTH      = 16;
    localparam int GAIN_WIDTH = 8;
    localparam int LAT        = COUNT + 2;
    localparam longint S_MAX  = 32767;
    localparam longint S_MIN  = -32768;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [COUNT*WIDTH-1:0] in_signal = '0;
    logic [COUNT-1:0]       mute = '0;
    logic                   sample_stb = 1'b0;
    logic                   gain_we = 1'b0;
    logic [3:0]             gain_sel = '0;
    logic [GAIN_WIDTH-1:0]  gain_data = '0;
    logic [WIDTH-1:0]       out_signal;
    logic                   out_valid;
    logic                   clip;
    logic                   busy;
    logic                   drop;

    sound_mixer_gain #(
        .COUNT      (COUNT),
        .WIDTH      (WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .IN_SIGNAL  (in_signal),
        .MUTE       (mute),
        .SAMPLE_STB (sample_stb),
        .GAIN_WE    (gain_we),
        .GAIN_SEL   (gain_sel),
        .GAIN_DATA  (gain_data),
        .OUT_SIGNAL (out_signal),
        .OUT_VALID  (out_valid),
        .CLIP       (clip),
        .BUSY       (busy),
        .DROP       (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_gain [COUNT] = '{default: 128};
    bit     p_active   = 1'b0;
    int     p_start    = 0;
    int     p_valid    = -1;
    longint p_out      = 0;
    bit     p_clip     = 1'b0;
    int     drop_cycle = -1;
    longint exp_out    = 0;
    bit     exp_clip   = 1'b0;

    // Weighted sum of the unmuted channels, rescaled with floor division.
    function automatic longint model_mix();
        longint acc = 0;
        for (int k = 0; k < COUNT; k++) begin
            if (!mute[k]) begin
                acc += longint'($signed(in_signal[k*WIDTH +: WIDTH])) * longint'(m_gain[k]);
            end
        end
        return acc >>> (GAIN_WIDTH - 1);
    endfunction

    // Inputs are stable at the rising edge; the model consumes them there.
    always @(posedge clk) begin
        longint s;
        if (rst) begin
            p_active   = 1'b0;
            drop_cycle = -1;
            for (int k = 0; k < COUNT; k++) m_gain[k] = 128;
        end else begin
            if (p_active && cyc >= p_valid) p_active = 1'b0;
            if (sample_stb) begin
                if (!p_active) begin
                    s        = model_mix();
                    p_active = 1'b1;
                    p_start  = cyc;
                    p_valid  = cyc + LAT;
                    if (s > S_MAX) begin
                        p_out = S_MAX; p_clip = 1'b1;
                    end else if (s < S_MIN) begin
                        p_out = S_MIN; p_clip = 1'b1;
                    end else begin
                        p_out = s; p_clip = 1'b0;
                    end
                end else begin
                    drop_cycle = cyc + 1;
                end
            end
            if (gain_we && gain_sel < COUNT) m_gain[gain_sel] = int'(gain_data);
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        bit e_valid, e_busy, e_drop;
        if (rst) begin
            exp_out  = 0;
            exp_clip = 1'b0;
        end
        e_valid = !rst && p_active && (cyc == p_valid);
        if (e_valid) begin
            exp_out  = p_out;
            exp_clip = p_clip;
        end
        e_busy = !rst && p_active && (cyc > p_start) && (cyc < p_valid);
        e_drop = !rst && (cyc == drop_cycle);
        check("cyc_out_valid", longint'(out_valid), longint'(e_valid));
        check("cyc_busy", longint'(busy), longint'(e_busy));
        check("cyc_drop", longint'(drop), longint'(e_drop));
        check("cyc_out_signal", longint'($signed(out_signal)), exp_out);
        check("cyc_clip", longint'(clip), longint'(exp_clip));
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
        sample_stb = 1'b0;
        gain_we    = 1'b0;
    endtask

    task automatic set_ch(input int k, input int v);
        in_signal[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic set_all(input int a, input int b, input int c, input int d);
        set_ch(0, a); set_ch(1, b); set_ch(2, c); set_ch(3, d);
    endtask

    task automatic write_gain(input int sel, input int val);
        gain_we   = 1'b1;
        gain_sel  = 4'(sel);
        gain_data = GAIN_WIDTH'(val);
        step();
    endtask

    task automatic strobe(output int scyc);
        scyc       = cyc;
        sample_stb = 1'b1;
        step();
    endtask

    task automatic wait_valid(output longint val, output bit clp, output int vcyc);
        bit found = 1'b0;
        val  = 0;
        clp  = 1'b0;
        vcyc = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                val   = longint'($signed(out_signal));
                clp   = clip;
                vcyc  = cyc;
            end
        end
        #1;
        check("valid_seen", longint'(found), 1);
    endtask

    task automatic mix(input string name, input longint exp_v, input bit exp_c);
        int     s, vc;
        longint v;
        bit     c;
        strobe(s);
        wait_valid(v, c, vc);
        check({name, "_value"}, v, exp_v);
        check({name, "_clip"}, longint'(c), longint'(exp_c));
        check({name, "_latency"}, longint'(vc - s), LAT);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int     s, vc, n_v;
        longint v;
        bit     c;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_signal", longint'($signed(out_signal)), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid", longint'(out_valid), 0);
        rst = 1'b0;
        step();

        // Basic mix at unity gain
        set_all(1000, 2000, -500, 0);
        mix("basic", 2500, 1'b0);

        // Saturation both ways, then back to an unclipped result
        set_all(32767, 32767, 32767, 32767);
        mix("sat_pos", 32767, 1'b1);
        set_all(-32768, -32768, -32768, -32768);
        mix("sat_neg", -32768, 1'b1);
        set_all(0, 0, 0, 0);
        mix("zero", 0, 1'b0);

        // Half gain, floor on negative, out-of-range gain write ignored
        write_gain(0, 64);
        set_all(1001, 0, 0, 0);
        mix("half_gain", 500, 1'b0);
        set_all(-1001, 0, 0, 0);
        mix("half_gain_floor", -501, 1'b0);
        write_gain(7, 0);
        set_all(1001, 0, 0, 0);
        mix("gain_sel_oob", 500, 1'b0);

        // Mute and input change after the strobe
        write_gain(0, 128);
        mute = 4'b0010;
        set_all(5, 10000, 0, 0);
        strobe(s);
        step();
        set_ch(0, 9);
        wait_valid(v, c, vc);
        check("mute_snapshot_value", v, 5);
        step();
        mute = '0;

        // Strobe while busy is dropped; strobe during OUT_VALID is accepted
        set_all(7, 0, 0, 0);
        strobe(s);
        step();
        set_ch(0, 11);
        sample_stb = 1'b1;
        step();
        check("drop_pulse", longint'(drop), 1);
        step();
        check("drop_once", longint'(drop), 0);
        wait_valid(v, c, vc);
        check("drop_first_snapshot", v, 7);
        s = cyc;
        sample_stb = 1'b1;
        step();
        wait_valid(v, c, vc);
        check("back_to_back_value", v, 11);
        check("back_to_back_latency", longint'(vc - s), LAT);
        step();

        // Reset mid-mix aborts and restores unity gains
        write_gain(0, 64);
        set_all(100, 0, 0, 0);
        strobe(s);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_out_signal", longint'($signed(out_signal)), 0);
        check("abort_busy", longint'(busy), 0);
        rst = 1'b0;
        n_v = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_v += int'(out_valid);
        end
        check("abort_no_valid", longint'(n_v), 0);
        mix("post_reset_unity", 100, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = 1'b0;
            for (int k = 0; k < COUNT; k++) begin
                if ($urandom_range(0, 3) == 0) set_ch(k, int'($urandom));
                else set_ch(k, int'($urandom_range(0, 4000)) - 2000);
            end
            mute       = COUNT'($urandom);
            sample_stb = ($urandom_range(0, 3) == 0);
            gain_we    = ($urandom_range(0, 5) == 0);
            gain_sel   = 4'($urandom_range(0, 15));
            gain_data  = GAIN_WIDTH'($urandom);
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
        end
        step();
        rst = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
